rvfi_trace_source: RTL and testbench
====================================

// Module: rvfi_trace_source
// PURPOSE
//  Drives RVFI retirement traffic replayed from a loadable trace memory. It is the
//  transmitting end of the RVFI interface and stands in for a core when exercising
//  rvfi checkers (hang, order, pc-continuity) in unit benches.
//  Supports multi-channel retirement, programmable idle gaps, halt records and a
//  deliberate hang injection, so that a liveness checker's pass and fail paths are both reachable.
// PARAMETERS
//  NRET   1   retirement channels per cycle (matches RISCV_FORMAL_NRET)
//  XLEN   32  data/pc width
//  DEPTH  16  trace records; AW = $clog2(DEPTH)
// PORTS
//  clock          in   1           clock
//  reset          in   1           synchronous, active-high
//  ld_en          in   1           write one trace record at ld_addr (accepted only in IDLE)
//  ld_addr        in   AW          record index
//  ld_insn        in   32          record insn
//  ld_pc          in   XLEN        record pc
//  ld_rd_addr     in   5           record rd
//  ld_rd_wdata    in   XLEN        record rd value
//  ld_trap        in   1           record trap flag
//  ld_halt        in   1           record halt flag
//  start          in   1           begin replay (accepted only in IDLE or DONE)
//  len            in   AW+1        records to replay; values > DEPTH are clamped to DEPTH
//  gap            in   8           idle cycles inserted after every retiring beat
//  hang_en        in   1           enable hang injection
//  hang_at        in   AW+1        retirement count at which replay freezes
//  abort          in   1           return to IDLE from any state
//  busy           out  1           state is RUN or GAP
//  done           out  1           state is DONE
//  hung           out  1           state is HANG
//  retired        out  AW+1        records emitted since the last start
//  rvfi_valid     out  NRET        per-channel valid
//  rvfi_order     out  NRET*64     retirement index
//  rvfi_insn      out  NRET*32     instruction word
//  rvfi_trap      out  NRET        trap flag
//  rvfi_halt      out  NRET        halt flag
//  rvfi_pc_rdata  out  NRET*XLEN   pc of the record
//  rvfi_pc_wdata  out  NRET*XLEN   pc of the next record; pc+4 for the last record
//  rvfi_rd_addr   out  NRET*5      rd index
//  rvfi_rd_wdata  out  NRET*XLEN   rd value; forced to 0 when rd_addr==0
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0. Trace RAM contents are not reset and survive a reset.
//  - All rvfi_* outputs are registered. The first beat appears the cycle after start.
//  - Payload fields of channels whose rvfi_valid is 0 are driven to 0.
//  - On start: latch len (clamped), gap, hang_en and hang_at; clear retired and ptr.
//    If len==0, go to DONE; otherwise go to RUN.
//  - RUN: emit k = min(NRET, len-ptr) records on channels 0..k-1, in ascending record order.
//    If hang_en, k is further limited to hang_at-retired.
//    rvfi_order = retired + channel index. After the beat, ptr and retired advance by k.
//  - After a beat: if a record with halt set was emitted, go to DONE; channels above the
//    halt record are not valid, and remaining records are discarded.
//    Else if ptr==len, go to DONE. Else if hang_en and retired==hang_at, go to HANG.
//    Else if gap!=0, go to GAP. Else stay in RUN.
//  - HANG is also entered directly from start when hang_en and hang_at==0.
//  - GAP: count down the latched gap with all valids 0, then return to RUN.
//  - HANG: valids stay 0 indefinitely; hung=1. Only reset or abort leaves HANG.
//  - DONE: done=1 and valids 0; a new start is accepted.
//  - abort: next state IDLE and outputs cleared. abort has priority over start in the same cycle.
//  - ld_en outside IDLE is ignored. start in RUN, GAP or HANG is ignored.
// TESTING
//  - NRET=1, len=3, gap=0, pcs 0,4,8 -> valid on cycles s+1..s+3, order 0,1,2, pc_wdata 4,8,12; done at s+4.
//  - NRET=2, len=5, gap=1 -> valid 11, 00, 11, 00, 01; orders {0,1},{2,3},{4}; done after the last beat.
//  - NRET=1, len=5, hang_en, hang_at=2 -> exactly 2 beats, then hung=1 and valid 0 for 100 cycles;
//    a hang checker asserted afterwards with okay cleared must fail.
//  - len=4 with halt set on record 1 -> records 0,1 emitted; rvfi_halt=1 on order 1; done; records 2,3 never appear.
//  - Reset asserted during RUN after 2 beats -> valid 0 next cycle. Restart replays record 0 with order 0, RAM intact.
//  - len=0 -> done=1 one cycle after start, no valid ever. start during RUN is ignored. rd_addr=0 gives rd_wdata=0.

Source files
------------

// File: rtl/rvfi_trace_source.sv
// rtl/rvfi_trace_source.sv - RVFI retirement traffic replayed from a loadable trace memory
//
// Stands in for a core on the RVFI interface so that rvfi checkers (hang, order,
// pc-continuity) can be driven from unit benches. Supports multi-channel
// retirement, idle gaps between beats, halt records and hang injection.
//
// Ports:
//   clock, reset            clock; synchronous active-high reset
//   ld_*                    write one trace record at ld_addr (only while IDLE)
//   start, len, gap         begin replay of len records (clamped to DEPTH), gap idle cycles per beat
//   hang_en, hang_at        freeze replay once hang_at records have retired
//   abort                   return to IDLE from any state, overrides start
//   busy, done, hung        state is RUN/GAP, DONE, HANG
//   retired                 records emitted since the last start
//   rvfi_*                  registered RVFI retirement channels, NRET wide
module rvfi_trace_source #(
   parameter int NRET  = 1,
   parameter int XLEN  = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ld_en,
   input  logic [AW-1:0]        ld_addr,
   input  logic [31:0]          ld_insn,
   input  logic [XLEN-1:0]      ld_pc,
   input  logic [4:0]           ld_rd_addr,
   input  logic [XLEN-1:0]      ld_rd_wdata,
   input  logic                 ld_trap,
   input  logic                 ld_halt,
   input  logic                 start,
   input  logic [AW:0]          len,
   input  logic [7:0]           gap,
   input  logic                 hang_en,
   input  logic [AW:0]          hang_at,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic                 hung,
   output logic [AW:0]          retired,
   output logic [NRET-1:0]      rvfi_valid,
   output logic [NRET*64-1:0]   rvfi_order,
   output logic [NRET*32-1:0]   rvfi_insn,
   output logic [NRET-1:0]      rvfi_trap,
   output logic [NRET-1:0]      rvfi_halt,
   output logic [NRET*XLEN-1:0] rvfi_pc_rdata,
   output logic [NRET*XLEN-1:0] rvfi_pc_wdata,
   output logic [NRET*5-1:0]    rvfi_rd_addr,
   output logic [NRET*XLEN-1:0] rvfi_rd_wdata
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RUN  = 3'd1;
   localparam logic [2:0] S_GAP  = 3'd2;
   localparam logic [2:0] S_HANG = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   // Trace memory: deliberately not reset so a reset mid-replay keeps the trace.
   logic [31:0]     mem_insn    [DEPTH];
   logic [XLEN-1:0] mem_pc      [DEPTH];
   logic [4:0]      mem_rd_addr [DEPTH];
   logic [XLEN-1:0] mem_rd_wdata[DEPTH];
   logic            mem_trap    [DEPTH];
   logic            mem_halt    [DEPTH];

   logic [2:0]  state;
   logic [AW:0] len_q, hang_at_q, ptr;
   logic [7:0]  gap_q, gap_cnt;
   logic        hang_en_q, halt_seen;

   always_ff @(posedge clock) begin
      if (ld_en && state == S_IDLE) begin
         mem_insn[ld_addr]     <= ld_insn;
         mem_pc[ld_addr]       <= ld_pc;
         mem_rd_addr[ld_addr]  <= ld_rd_addr;
         mem_rd_wdata[ld_addr] <= ld_rd_wdata;
         mem_trap[ld_addr]     <= ld_trap;
         mem_halt[ld_addr]     <= ld_halt;
      end
   end

   // The first beat issues on the same edge that accepts start, so the beat
   // logic works from "effective" parameters: the incoming ones on a start,
   // the latched ones otherwise.
   logic        start_ok, hang_reached, do_beat, halt_hit, terminal, stop;
   logic [AW:0] len_clamp, eff_len, eff_hang_at, eff_ptr, eff_retired;
   logic [AW:0] n_cnt, nptr, nret;
   logic [7:0]  eff_gap;
   logic        eff_hang_en;
   logic [2:0]  post_state;
   logic [31:0] pos, pos1, rpos;
   logic [AW-1:0] idx;
   logic [NRET-1:0]      emit, beat_trap, beat_halt;
   logic [NRET*64-1:0]   beat_order;
   logic [NRET*32-1:0]   beat_insn;
   logic [NRET*XLEN-1:0] beat_pc_rdata, beat_pc_wdata, beat_rd_wdata;
   logic [NRET*5-1:0]    beat_rd_addr;

   always_comb begin
      start_ok     = start && !abort && (state == S_IDLE || state == S_DONE);
      len_clamp    = (len > DEPTH_W) ? DEPTH_W : len;
      eff_len      = start_ok ? len_clamp : len_q;
      eff_gap      = start_ok ? gap : gap_q;
      eff_hang_en  = start_ok ? hang_en : hang_en_q;
      eff_hang_at  = start_ok ? hang_at : hang_at_q;
      eff_ptr      = start_ok ? '0 : ptr;
      eff_retired  = start_ok ? '0 : retired;
      hang_reached = eff_hang_en && (eff_retired == eff_hang_at);
      if (abort)
         do_beat = 1'b0;
      else if (start_ok)
         do_beat = (len_clamp != '0) && !hang_reached;
      else
         do_beat = (state == S_RUN) && !halt_seen && (ptr != len_q) && !hang_reached;
   end

   // Channels fill in record order until the replay length, the hang point or
   // a halt record cuts the beat short.
   always_comb begin
      emit          = '0;
      beat_order    = '0;
      beat_insn     = '0;
      beat_trap     = '0;
      beat_halt     = '0;
      beat_pc_rdata = '0;
      beat_pc_wdata = '0;
      beat_rd_addr  = '0;
      beat_rd_wdata = '0;
      n_cnt         = '0;
      halt_hit      = 1'b0;
      stop          = 1'b0;
      pos           = '0;
      pos1          = '0;
      rpos          = '0;
      idx           = '0;
      for (int c = 0; c < NRET; c++) begin
         pos  = 32'(eff_ptr) + 32'(c);
         pos1 = pos + 32'd1;
         rpos = 32'(eff_retired) + 32'(c);
         idx  = pos[AW-1:0];
         if (!stop && pos < 32'(eff_len) && (!eff_hang_en || rpos < 32'(eff_hang_at))) begin
            emit[c]                    = 1'b1;
            n_cnt                      = n_cnt + (AW+1)'(1);
            beat_order[c*64 +: 64]     = 64'(rpos);
            beat_insn[c*32 +: 32]      = mem_insn[idx];
            beat_trap[c]               = mem_trap[idx];
            beat_halt[c]               = mem_halt[idx];
            beat_pc_rdata[c*XLEN +: XLEN] = mem_pc[idx];
            beat_pc_wdata[c*XLEN +: XLEN] = (pos1 < 32'(eff_len)) ? mem_pc[pos1[AW-1:0]]
                                                                  : mem_pc[idx] + XLEN'(4);
            beat_rd_addr[c*5 +: 5]     = mem_rd_addr[idx];
            beat_rd_wdata[c*XLEN +: XLEN] = (mem_rd_addr[idx] == 5'd0) ? '0 : mem_rd_wdata[idx];
            if (mem_halt[idx]) begin
               halt_hit = 1'b1;
               stop     = 1'b1;
            end
         end else begin
            stop = 1'b1;
         end
      end
      nptr     = eff_ptr + n_cnt;
      nret     = eff_retired + n_cnt;
      // A finishing beat parks in RUN for one cycle; RUN then resolves to DONE
      // or HANG, so done/hung rise the cycle after the last valid beat.
      terminal = halt_hit || (nptr == eff_len) || (eff_hang_en && nret == eff_hang_at);
      if (terminal)
         post_state = S_RUN;
      else if (eff_gap != 8'd0)
         post_state = S_GAP;
      else
         post_state = S_RUN;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= S_IDLE;
         len_q         <= '0;
         gap_q         <= '0;
         gap_cnt       <= '0;
         hang_en_q     <= 1'b0;
         hang_at_q     <= '0;
         ptr           <= '0;
         halt_seen     <= 1'b0;
         retired       <= '0;
         rvfi_valid    <= '0;
         rvfi_order    <= '0;
         rvfi_insn     <= '0;
         rvfi_trap     <= '0;
         rvfi_halt     <= '0;
         rvfi_pc_rdata <= '0;
         rvfi_pc_wdata <= '0;
         rvfi_rd_addr  <= '0;
         rvfi_rd_wdata <= '0;
      end else begin
         rvfi_valid    <= do_beat ? emit          : '0;
         rvfi_order    <= do_beat ? beat_order    : '0;
         rvfi_insn     <= do_beat ? beat_insn     : '0;
         rvfi_trap     <= do_beat ? beat_trap     : '0;
         rvfi_halt     <= do_beat ? beat_halt     : '0;
         rvfi_pc_rdata <= do_beat ? beat_pc_rdata : '0;
         rvfi_pc_wdata <= do_beat ? beat_pc_wdata : '0;
         rvfi_rd_addr  <= do_beat ? beat_rd_addr  : '0;
         rvfi_rd_wdata <= do_beat ? beat_rd_wdata : '0;
         if (start_ok) begin
            len_q     <= len_clamp;
            gap_q     <= gap;
            hang_en_q <= hang_en;
            hang_at_q <= hang_at;
         end
         if (abort) begin
            state     <= S_IDLE;
            ptr       <= '0;
            retired   <= '0;
            halt_seen <= 1'b0;
            gap_cnt   <= '0;
         end else if (do_beat) begin
            ptr       <= nptr;
            retired   <= nret;
            halt_seen <= halt_hit;
            gap_cnt   <= eff_gap;
            state     <= post_state;
         end else if (start_ok) begin
            ptr       <= '0;
            retired   <= '0;
            halt_seen <= 1'b0;
            state     <= (len_clamp == '0) ? S_DONE : S_HANG;
         end else begin
            case (state)
               S_RUN:   state <= (halt_seen || ptr == len_q) ? S_DONE : S_HANG;
               S_GAP:   begin
                  if (gap_cnt <= 8'd1)
                     state <= S_RUN;
                  else
                     gap_cnt <= gap_cnt - 8'd1;
               end
               default: state <= state;
            endcase
         end
      end
   end

   assign busy = (state == S_RUN) || (state == S_GAP);
   assign done = (state == S_DONE);
   assign hung = (state == S_HANG);

endmodule

// File: tb/tb_rvfi_trace_source.sv
// tb/tb_rvfi_trace_source.sv - directed bench for rvfi_trace_source (NRET=1 and NRET=2 instances)
module tb_rvfi_trace_source;
   localparam int XLEN  = 32;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic            reset, ld_en, ld_trap, ld_halt, start, hang_en, abort;
   logic [AW-1:0]   ld_addr;
   logic [31:0]     ld_insn;
   logic [XLEN-1:0] ld_pc, ld_rd_wdata;
   logic [4:0]      ld_rd_addr;
   logic [AW:0]     len, hang_at;
   logic [7:0]      gap;

   logic a_busy, a_done, a_hung;
   logic [AW:0] a_retired;
   logic [0:0] a_valid, a_trap, a_halt;
   logic [63:0] a_order;
   logic [31:0] a_insn, a_pc_rdata, a_pc_wdata, a_rd_wdata;
   logic [4:0] a_rd_addr;

   logic b_busy, b_done, b_hung;
   logic [AW:0] b_retired;
   logic [1:0] b_valid, b_trap, b_halt;
   logic [127:0] b_order;
   logic [63:0] b_insn, b_pc_rdata, b_pc_wdata, b_rd_wdata;
   logic [9:0] b_rd_addr;

   rvfi_trace_source #(.NRET(1), .XLEN(XLEN), .DEPTH(DEPTH)) u1 (
      .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_insn(ld_insn),
      .ld_pc(ld_pc), .ld_rd_addr(ld_rd_addr), .ld_rd_wdata(ld_rd_wdata), .ld_trap(ld_trap),
      .ld_halt(ld_halt), .start(start), .len(len), .gap(gap), .hang_en(hang_en),
      .hang_at(hang_at), .abort(abort), .busy(a_busy), .done(a_done), .hung(a_hung),
      .retired(a_retired), .rvfi_valid(a_valid), .rvfi_order(a_order), .rvfi_insn(a_insn),
      .rvfi_trap(a_trap), .rvfi_halt(a_halt), .rvfi_pc_rdata(a_pc_rdata),
      .rvfi_pc_wdata(a_pc_wdata), .rvfi_rd_addr(a_rd_addr), .rvfi_rd_wdata(a_rd_wdata));

   rvfi_trace_source #(.NRET(2), .XLEN(XLEN), .DEPTH(DEPTH)) u2 (
      .clock(clock), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_insn(ld_insn),
      .ld_pc(ld_pc), .ld_rd_addr(ld_rd_addr), .ld_rd_wdata(ld_rd_wdata), .ld_trap(ld_trap),
      .ld_halt(ld_halt), .start(start), .len(len), .gap(gap), .hang_en(hang_en),
      .hang_at(hang_at), .abort(abort), .busy(b_busy), .done(b_done), .hung(b_hung),
      .retired(b_retired), .rvfi_valid(b_valid), .rvfi_order(b_order), .rvfi_insn(b_insn),
      .rvfi_trap(b_trap), .rvfi_halt(b_halt), .rvfi_pc_rdata(b_pc_rdata),
      .rvfi_pc_wdata(b_pc_wdata), .rvfi_rd_addr(b_rd_addr), .rvfi_rd_wdata(b_rd_wdata));

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Record i: insn 0x1000_000i, rd=i, rd value 0xA000_000i, trap only on record 2.
   task automatic load(input int a, input logic [31:0] pc, input logic halt);
      ld_addr     = AW'(a);
      ld_insn     = 32'h1000_0000 | 32'(a);
      ld_pc       = pc;
      ld_rd_addr  = 5'(a);
      ld_rd_wdata = 32'hA000_0000 | 32'(a);
      ld_trap     = (a == 2);
      ld_halt     = halt;
      ld_en       = 1'b1;
      step();
      ld_en       = 1'b0;
   endtask

   task automatic go(input int l, input int g, input logic he, input int ha);
      len     = (AW+1)'(l);
      gap     = 8'(g);
      hang_en = he;
      hang_at = (AW+1)'(ha);
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   logic [1:0] exp_v [5] = '{2'b11, 2'b00, 2'b11, 2'b00, 2'b01};
   int seen, cnt;
   logic [31:0] last_wd;
   logic [63:0] last_ord;

   initial begin
      reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_insn = '0; ld_pc = '0; ld_rd_addr = '0;
      ld_rd_wdata = '0; ld_trap = 1'b0; ld_halt = 1'b0; start = 1'b0; len = '0; gap = '0;
      hang_en = 1'b0; hang_at = '0; abort = 1'b0;
      step(); step(); step();
      check("rst_valid", a_valid, 0);
      check("rst_busy_done_hung", {a_busy, a_done, a_hung}, 0);
      check("rst_retired", a_retired, 0);
      check("rst_b_valid", b_valid, 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 8; i++) load(i, 32'(4 * i), 1'b0);

      // basic replay, NRET=1, and start during RUN ignored
      go(3, 0, 1'b0, 0);
      check("a1_valid", a_valid, 1);
      check("a1_order", a_order, 0);
      check("a1_insn", a_insn, 32'h1000_0000);
      check("a1_pc_wdata", a_pc_wdata, 4);
      check("a1_rd0_wdata", a_rd_wdata, 0);
      check("a1_busy", a_busy, 1);
      len = 5'd1; start = 1'b1;
      step();
      start = 1'b0;
      check("a2_valid", a_valid, 1);
      check("a2_order", a_order, 1);
      check("a2_rd_addr", a_rd_addr, 1);
      check("a2_rd_wdata", a_rd_wdata, 32'hA000_0001);
      check("a2_pc_wdata", a_pc_wdata, 8);
      check("b2_valid_partial", b_valid, 2'b01);
      check("b2_order_ch0", b_order[63:0], 2);
      check("b2_idle_ch_pc", b_pc_rdata[63:32], 0);
      step();
      check("a3_valid", a_valid, 1);
      check("a3_order", a_order, 2);
      check("a3_pc_rdata", a_pc_rdata, 8);
      check("a3_pc_wdata", a_pc_wdata, 12);
      check("a3_trap", a_trap, 1);
      check("a3_done_early", a_done, 0);
      step();
      check("a4_valid", a_valid, 0);
      check("a4_done", a_done, 1);
      check("a4_retired", a_retired, 3);
      check("a4_busy", a_busy, 0);

      // NRET=2 with gap=1
      go(5, 1, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         check($sformatf("b_gap_valid%0d", i), b_valid, exp_v[i]);
         if (i == 0) check("b_gap_ord01", b_order, {64'd1, 64'd0});
         if (i == 2) check("b_gap_ord23", b_order, {64'd3, 64'd2});
         if (i == 4) begin
            check("b_gap_ord4", b_order, {64'd0, 64'd4});
            check("b_gap_last_wdata", b_pc_wdata[31:0], 20);
            check("b_gap_done_early", b_done, 0);
         end
      end
      step();
      check("b_gap_done", b_done, 1);
      check("b_gap_valid_after", b_valid, 0);
      for (int i = 0; i < 40 && !a_done; i++) step();
      check("a_gap_done", a_done, 1);
      check("a_gap_retired", a_retired, 5);

      // hang injection after two beats
      go(5, 0, 1'b1, 2);
      check("h1_valid", a_valid, 1);
      check("h1_order", a_order, 0);
      step();
      check("h2_order", a_order, 1);
      step();
      check("h3_valid", a_valid, 0);
      check("h3_hung", a_hung, 1);
      check("h3_retired", a_retired, 2);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (a_valid != 0 || b_valid != 0) seen++;
      end
      check("h_no_valid_100", seen, 0);
      check("h_still_hung", a_hung, 1);
      go(3, 0, 1'b0, 0);
      check("h_start_ignored", a_hung, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("h_abort_hung", a_hung, 0);
      check("h_abort_retired", a_retired, 0);
      abort = 1'b1; len = 5'd3; start = 1'b1;
      step();
      abort = 1'b0; start = 1'b0;
      check("abort_over_start", {a_busy, a_done, a_valid}, 0);

      // hang_at==0 goes straight to HANG
      go(3, 0, 1'b1, 0);
      check("h0_hung", a_hung, 1);
      check("h0_valid", a_valid, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;

      // halt on record 1
      load(1, 32'd4, 1'b1);
      go(4, 0, 1'b0, 0);
      check("t1_order", a_order, 0);
      step();
      check("t2_valid", a_valid, 1);
      check("t2_order", a_order, 1);
      check("t2_halt", a_halt, 1);
      check("t2_pc_wdata", a_pc_wdata, 8);
      step();
      check("t3_valid", a_valid, 0);
      check("t3_done", a_done, 1);
      check("t3_retired", a_retired, 2);
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (a_valid != 0) seen++;
      end
      check("t_no_more", seen, 0);

      // load while DONE is ignored; reset mid-run keeps the RAM
      load(0, 32'h100, 1'b0);
      go(5, 0, 1'b0, 0);
      step();
      check("r2_order", a_order, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("r_valid", a_valid, 0);
      check("r_retired", a_retired, 0);
      check("r_state", {a_busy, a_done, a_hung}, 0);
      go(1, 0, 1'b0, 0);
      check("r_re_valid", a_valid, 1);
      check("r_re_order", a_order, 0);
      check("r_re_pc", a_pc_rdata, 0);
      check("r_re_insn", a_insn, 32'h1000_0000);
      step();
      check("r_re_done", a_done, 1);

      // len=0
      go(0, 0, 1'b0, 0);
      check("z_done", a_done, 1);
      check("z_valid", a_valid, 0);
      step();
      check("z_valid2", a_valid, 0);

      // len above DEPTH clamps to DEPTH
      abort = 1'b1;
      step();
      abort = 1'b0;
      for (int i = 0; i < 16; i++) load(i, 32'(4 * i), 1'b0);
      go(31, 0, 1'b0, 0);
      cnt = 0; last_wd = '0; last_ord = '0;
      for (int i = 0; i < 40 && !a_done; i++) begin
         if (a_valid != 0) begin
            cnt++;
            last_wd  = a_pc_wdata;
            last_ord = a_order;
         end
         step();
      end
      check("c_done", a_done, 1);
      check("c_beats", cnt, 16);
      check("c_last_order", last_ord, 15);
      check("c_last_wdata", last_wd, 64);
      check("c_retired", a_retired, 16);
      check("c_b_retired", b_retired, 16);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
